// File: rtl/sbox_arbiter.sv
// Round-robin arbiter that shares one registered S-box between the subbytes (0)
// and key-schedule (1) requesters, with a burst limit and per-requester result return.
module sbox_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_decrypt_i,
  output logic       grant0_o,
  output logic       valid0_o,
  output logic [7:0] result0_o,
  input  logic       req1_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_decrypt_i,
  output logic       grant1_o,
  output logic       valid1_o,
  output logic [7:0] result1_o,
  output logic [7:0] sbox_data_o,
  output logic       sbox_decrypt_o,
  input  logic [7:0] sbox_data_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_BURST);

  state_t     state, next_state;
  logic       rr, next_rr;
  logic [4:0] cnt, next_cnt;
  logic       issued0, issued1;

  // Issue tags remember who got the S-box so its answer returns to them next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      rr      <= 1'b1;
      issued0 <= 1'b0;
      issued1 <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      rr      <= next_rr;
      issued0 <= grant0_o;
      issued1 <= grant1_o;
    end
  end

  // The owner keeps the S-box until it drops its request or exhausts its burst
  // while the other side waits; handover always grants in the same cycle.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_rr    = rr;
    grant0_o   = 1'b0;
    grant1_o   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_i && (!req1_i || rr)) begin
          grant0_o   = 1'b1;
          next_state = OWN0;
          next_cnt   = 5'd1;
        end else if (req1_i) begin
          grant1_o   = 1'b1;
          next_state = OWN1;
          next_cnt   = 5'd1;
        end
      end
      OWN0: begin
        if (req0_i && (cnt < MAX_CNT || !req1_i)) begin
          grant0_o = 1'b1;
          if (cnt < MAX_CNT) next_cnt = cnt + 5'd1;
        end else begin
          next_rr = 1'b0;
          if (req1_i) begin
            grant1_o   = 1'b1;
            next_state = OWN1;
            next_cnt   = 5'd1;
          end else begin
            next_state = IDLE;
            next_cnt   = 5'd0;
          end
        end
      end
      OWN1: begin
        if (req1_i && (cnt < MAX_CNT || !req0_i)) begin
          grant1_o = 1'b1;
          if (cnt < MAX_CNT) next_cnt = cnt + 5'd1;
        end else begin
          next_rr = 1'b1;
          if (req0_i) begin
            grant0_o   = 1'b1;
            next_state = OWN0;
            next_cnt   = 5'd1;
          end else begin
            next_state = IDLE;
            next_cnt   = 5'd0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 5'd0;
      end
    endcase
  end

  always_comb begin
    sbox_data_o    = 8'h00;
    sbox_decrypt_o = 1'b0;
    if (grant0_o) begin
      sbox_data_o    = req0_data_i;
      sbox_decrypt_o = req0_decrypt_i;
    end else if (grant1_o) begin
      sbox_data_o    = req1_data_i;
      sbox_decrypt_o = req1_decrypt_i;
    end
  end

  assign valid0_o  = issued0;
  assign valid1_o  = issued1;
  assign result0_o = issued0 ? sbox_data_i : 8'h00;
  assign result1_o = issued1 ? sbox_data_i : 8'h00;

endmodule

// File: doc/sbox_arbiter.md
SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, sets the maximum consecutive lookups one requester may issue while the other is waiting (legal range 1..31).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req0_i  input  1  requester 0 (subbytes) asks for a lookup this cycle.
REQ-005 req0_data_i  input  8  requester 0 byte to substitute.
REQ-006 req0_decrypt_i  input  1  requester 0 selects inverse S-box.
REQ-007 grant0_o  output  1  requester 0 lookup issued this cycle (combinational).
REQ-008 valid0_o  output  1  requester 0 result present this cycle (registered).
REQ-009 result0_o  output  8  requester 0 substituted byte.
REQ-010 req1_i, req1_data_i[7:0], req1_decrypt_i, grant1_o, valid1_o, result1_o[7:0] SHALL mirror REQ-004..REQ-009 for requester 1 (key schedule).
REQ-011 sbox_data_o  output  8  byte driven to the shared S-box.
REQ-012 sbox_decrypt_o  output  1  inverse select driven to the shared S-box.
REQ-013 sbox_data_i  input  8  S-box result, one cycle after sbox_data_o.

Function
REQ-014 States: IDLE, OWN0, OWN1; a last-owner bit (rr) and a burst counter (5 bits, saturating at MAX_BURST).
REQ-015 At most one of grant0_o/grant1_o SHALL be high in any cycle; a grant SHALL only be given to a requester whose req is high that cycle.
REQ-016 IDLE: single request -> grant it same cycle, go OWNx, counter=1; both requesting -> grant the requester not equal rr; none -> stay IDLE, no grant.
REQ-017 OWNx with reqx high and (counter < MAX_BURST or other req low): grant x, stay OWNx, counter increments (saturating).
REQ-018 OWNx with reqx high, counter = MAX_BURST and other req high: grant other same cycle, go OWN(other), counter=1, rr=x.
REQ-019 OWNx with reqx low: if other req high grant other same cycle, go OWN(other), counter=1; else go IDLE, counter=0; rr=x in both cases.
REQ-020 A grant SHALL never be withheld when at least one request is present (no idle bubble on handover).
REQ-021 sbox_data_o/sbox_decrypt_o SHALL equal the granted requester's data/decrypt in the grant cycle, and 0/0 when no grant.
REQ-022 An issue-tag register SHALL record which requester was granted; validx_o SHALL be high exactly one cycle after each grantx_o cycle.
REQ-023 resultx_o SHALL equal sbox_data_i while validx_o is high and 0 otherwise.
REQ-024 Back-to-back grants to one requester SHALL yield back-to-back valids, one result per cycle, in issue order.

Reset
REQ-025 While reset is high at a clock edge: state=IDLE, counter=0, rr=1 (requester 0 wins the first tie), issue tag cleared.
REQ-026 After reset, valid0_o=valid1_o=0 and result0_o=result1_o=0; a lookup granted in the cycle of reset SHALL produce no valid.
REQ-027 Grants are combinational and SHALL still follow REQ-016 in the first cycle after reset deassertion.

Verification
REQ-028 Reset, then req0_i high 16 cycles with data 0x00..0x0F, req1_i low -> grant0_o high 16 cycles, valid0_o high cycles 2..17, result0_o = S-box of 0x00..0x0F (0x63,0x7C,...).
REQ-029 Both req high from the first post-reset cycle -> grant0 first; with MAX_BURST=4 pattern is 4x grant0, 4x grant1, 4x grant0 with no gap cycles.
REQ-030 req1_i held, req0_i pulses one cycle while OWN1 with counter<MAX_BURST -> req0 not granted until req1 releases or limit reached; handover grant in the release cycle.
REQ-031 req0_decrypt_i=1, data 0x63 -> sbox_decrypt_o=1 in grant cycle, result0_o=0x00 next cycle; with no requests sbox_data_o=0x00, sbox_decrypt_o=0.
REQ-032 Reset asserted in a cycle with grant1_o high -> next cycle valid1_o=0, state IDLE; a subsequent tie grants requester 0.
REQ-033 Random req/data on both ports for 10k cycles -> never two grants, every grant followed by exactly one matching valid, no requester waits longer than MAX_BURST+1 cycles.
